// File: rtl/conv_mac_seq.sv
// Time-multiplexed KxK convolution MAC: one channel window per beat,
// CH_IN beats per output pixel, bias + shift + optional ReLU + saturate.
module conv_mac_seq #(
  parameter int IN_BITS  = 12,
  parameter int W_BITS   = 8,
  parameter int K        = 5,
  parameter int CH_IN    = 3,
  parameter int ACC_BITS = 28,
  parameter int SHIFT    = 6,
  parameter int OUT_BITS = 14,
  parameter int RELU     = 0,
  localparam int NT = K * K,
  localparam int CW = (CH_IN > 1) ? $clog2(CH_IN) : 1,
  localparam int IW = $clog2(NT + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       win_valid,
  output logic                       win_ready,
  input  logic [NT*IN_BITS-1:0]      win_data,
  input  logic                       wr_en,
  input  logic [CW-1:0]              wr_ch,
  input  logic [IW-1:0]              wr_idx,
  input  logic [W_BITS-1:0]          wr_data,
  output logic                       wr_err,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_BITS-1:0]        out_data
);

  localparam int PW = IN_BITS + W_BITS;
  localparam int RW = ACC_BITS - SHIFT;
  localparam logic signed [RW-1:0] OMAX = RW'(2 ** (OUT_BITS - 1) - 1);
  localparam logic signed [RW-1:0] OMIN = -OMAX - RW'(1);

  logic signed [W_BITS-1:0]   w [CH_IN][NT];
  logic signed [W_BITS-1:0]   bias;
  logic [CW-1:0]              ch_cnt;
  logic signed [PW-1:0]       prod [NT];
  logic signed [ACC_BITS-1:0] dot_c, dot, acc, acc_new;
  logic                       dot_vld, dot_first, dot_last;
  logic                       stall, accept, wr_ok, ch_last;
  logic signed [RW-1:0]       r, r_relu;
  logic signed [OUT_BITS-1:0] r_sat;

  assign stall     = out_valid & ~out_ready;
  assign win_ready = ~stall;
  assign accept    = win_valid & win_ready;
  assign busy      = (ch_cnt != '0) | dot_vld;
  assign ch_last   = (32'(ch_cnt) == CH_IN - 1);
  assign wr_ok     = ~busy & (32'(wr_idx) <= NT) & (32'(wr_ch) < CH_IN);

  always_comb begin
    dot_c = '0;
    for (int i = 0; i < NT; i++) begin
      prod[i] = PW'($signed(win_data[i*IN_BITS +: IN_BITS]))
              * PW'(w[ch_cnt][i]);
      dot_c = dot_c + ACC_BITS'(prod[i]);
    end
  end

  always_comb begin
    acc_new = dot_first ? (ACC_BITS'(bias) <<< SHIFT) + dot
                        : acc + dot;
    r      = RW'(acc_new >>> SHIFT);
    r_relu = (RELU != 0 && r < 0) ? '0 : r;
    if (r_relu > OMAX)
      r_sat = OUT_BITS'(OMAX);
    else if (r_relu < OMIN)
      r_sat = OUT_BITS'(OMIN);
    else
      r_sat = OUT_BITS'(r_relu);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CH_IN; c++)
        for (int i = 0; i < NT; i++)
          w[c][i] <= '0;
      bias      <= '0;
      ch_cnt    <= '0;
      dot       <= '0;
      dot_vld   <= 1'b0;
      dot_first <= 1'b0;
      dot_last  <= 1'b0;
      acc       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      wr_err    <= 1'b0;
    end else begin
      wr_err <= wr_en & ~wr_ok;
      if (wr_en & wr_ok) begin
        if (32'(wr_idx) == NT)
          bias <= wr_data;
        else
          w[wr_ch][wr_idx] <= wr_data;
      end
      if (!stall) begin
        if (accept) begin
          dot       <= dot_c;
          dot_vld   <= 1'b1;
          dot_first <= (ch_cnt == '0);
          dot_last  <= ch_last;
          ch_cnt    <= ch_last ? '0 : ch_cnt + CW'(1);
        end else begin
          dot_vld <= 1'b0;
        end
      end
      // A new result may load in the same cycle the old one pops
      if (dot_vld & ~stall) begin
        acc <= acc_new;
        if (dot_last) begin
          out_data  <= r_sat;
          out_valid <= 1'b1;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_seq.sv
// Directed bench for conv_mac_seq: a RELU=0 and a RELU=1 instance
// share all inputs; hand-computed expected results.
module tb_conv_mac_seq;

  localparam int NT = 25;
  localparam int IB = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              win_valid;
  logic [NT*IB-1:0]  win_data;
  logic              wr_en;
  logic [1:0]        wr_ch;
  logic [4:0]        wr_idx;
  logic [7:0]        wr_data;
  logic              out_ready;
  logic              win_ready, wr_err, busy, out_valid;
  logic [13:0]       out_data;
  logic              win_ready_r, wr_err_r, busy_r, out_valid_r;
  logic [13:0]       out_data_r;

  int n_cmp = 0;
  int n_bad = 0;

  conv_mac_seq #(.RELU(0)) dut (
    .clk(clk), .rst(rst),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_idx(wr_idx), .wr_data(wr_data),
    .wr_err(wr_err), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  conv_mac_seq #(.RELU(1)) dut_r (
    .clk(clk), .rst(rst),
    .win_valid(win_valid), .win_ready(win_ready_r), .win_data(win_data),
    .wr_en(wr_en), .wr_ch(wr_ch), .wr_idx(wr_idx), .wr_data(wr_data),
    .wr_err(wr_err_r), .busy(busy_r),
    .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r)
  );

  function automatic logic [NT*IB-1:0] tap12(input int v);
    logic [NT*IB-1:0] d;
    d = '0;
    d[12*IB +: IB] = v[IB-1:0];
    return d;
  endfunction

  function automatic logic [NT*IB-1:0] fill(input int v);
    logic [NT*IB-1:0] d;
    for (int i = 0; i < NT; i++) d[i*IB +: IB] = v[IB-1:0];
    return d;
  endfunction

  function automatic logic [NT*IB-1:0] rnd();
    logic [NT*IB-1:0] d;
    for (int i = 0; i < NT; i++) d[i*IB +: IB] = 12'($urandom);
    return d;
  endfunction

  task automatic write_w(input int ch, input int idx, input int val);
    wr_en   = 1'b1;
    wr_ch   = ch[1:0];
    wr_idx  = idx[4:0];
    wr_data = val[7:0];
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic set_all(input int wv, input int bv);
    for (int c = 0; c < 3; c++)
      for (int i = 0; i < NT; i++)
        write_w(c, i, wv);
    write_w(0, NT, bv);
  endtask

  task automatic set_tap12();
    for (int c = 0; c < 3; c++) write_w(c, 12, 1);
  endtask

  task automatic run_pixel(input logic [NT*IB-1:0] d0,
                           input logic [NT*IB-1:0] d1,
                           input logic [NT*IB-1:0] d2,
                           output logic [13:0] r,
                           output logic [13:0] rr,
                           output int lat);
    logic [NT*IB-1:0] d [3];
    d[0] = d0; d[1] = d1; d[2] = d2;
    for (int b = 0; b < 3; b++) begin
      win_valid = 1'b1;
      win_data  = d[b];
      @(negedge clk);
    end
    win_valid = 1'b0;
    lat = -1;
    r   = 'x;
    rr  = 'x;
    for (int n = 1; n <= 10; n++) begin
      if (out_valid) begin
        lat = n;
        r   = out_data;
        rr  = out_data_r;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    win_valid = 1'b0; win_data = '0;
    wr_en = 1'b0; wr_ch = '0; wr_idx = '0; wr_data = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    n_cmp++;
    if (out_data !== 14'd0) begin
      n_bad++; $display("FAIL reset_out_data: got %0d expected 0", out_data);
    end
    n_cmp++;
    if (wr_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_wr_err: got %b expected 0", wr_err);
    end
    n_cmp++;
    if (win_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_win_ready: got %b expected 1", win_ready);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_zero_weights();
    logic [13:0] r, rr;
    int lat;
    run_pixel(rnd(), rnd(), rnd(), r, rr, lat);
    n_cmp++;
    if (r !== 14'd0) begin
      n_bad++; $display("FAIL zero_result: got %0d expected 0", $signed(r));
    end
    n_cmp++;
    if (lat !== 2) begin
      n_bad++; $display("FAIL zero_latency: got %0d expected 2", lat);
    end
  endtask

  task automatic test_basic();
    logic [13:0] r, rr;
    int lat;
    set_tap12();
    run_pixel(tap12(640), tap12(640), tap12(640), r, rr, lat);
    n_cmp++;
    if (r !== 14'd30) begin
      n_bad++; $display("FAIL basic_result: got %0d expected 30", $signed(r));
    end
    n_cmp++;
    if (lat !== 2) begin
      n_bad++; $display("FAIL basic_latency: got %0d expected 2", lat);
    end
  endtask

  task automatic test_saturation();
    logic [13:0] r, rr;
    int lat;
    set_all(127, 0);
    run_pixel(fill(2047), fill(2047), fill(2047), r, rr, lat);
    n_cmp++;
    if (r !== 14'd8191) begin
      n_bad++; $display("FAIL sat_pos: got %0d expected 8191", $signed(r));
    end
    n_cmp++;
    if (rr !== 14'd8191) begin
      n_bad++; $display("FAIL sat_pos_relu: got %0d expected 8191", $signed(rr));
    end
    set_all(-128, 0);
    run_pixel(fill(2047), fill(2047), fill(2047), r, rr, lat);
    n_cmp++;
    if (r !== 14'h2000) begin
      n_bad++; $display("FAIL sat_neg: got %0d expected -8192", $signed(r));
    end
    n_cmp++;
    if (rr !== 14'd0) begin
      n_bad++; $display("FAIL sat_neg_relu: got %0d expected 0", $signed(rr));
    end
    set_all(0, 1);
    run_pixel(rnd(), rnd(), rnd(), r, rr, lat);
    n_cmp++;
    if (r !== 14'd1) begin
      n_bad++; $display("FAIL bias_only: got %0d expected 1", $signed(r));
    end
    n_cmp++;
    if (rr !== 14'd1) begin
      n_bad++; $display("FAIL bias_only_relu: got %0d expected 1", $signed(rr));
    end
    set_all(0, 0);
    set_tap12();
  endtask

  task automatic test_backpressure();
    logic [13:0] pops [$];
    out_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      win_valid = 1'b1;
      win_data  = tap12(b < 3 ? 640 : 1280);
      n_cmp++;
      if (win_ready !== 1'b1) begin
        n_bad++; $display("FAIL bp_ready_beat%0d: got %b expected 1", b, win_ready);
      end
      @(negedge clk);
    end
    win_data = tap12(1280);
    for (int n = 0; n < 4; n++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || win_ready !== 1'b0 || out_data !== 14'd30) begin
        n_bad++;
        $display("FAIL bp_stall_%0d: got valid=%b ready=%b data=%0d expected 1 0 30",
                 n, out_valid, win_ready, $signed(out_data));
      end
      if (n < 3) @(negedge clk);
    end
    out_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      if (out_valid && out_ready) pops.push_back(out_data);
      if (n == 1) win_data = tap12(1280);
      if (n == 2) win_valid = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if (pops.size() !== 2) begin
      n_bad++; $display("FAIL bp_pop_count: got %0d expected 2", pops.size());
    end else begin
      n_cmp++;
      if (pops[0] !== 14'd30) begin
        n_bad++; $display("FAIL bp_pop0: got %0d expected 30", $signed(pops[0]));
      end
      n_cmp++;
      if (pops[1] !== 14'd60) begin
        n_bad++; $display("FAIL bp_pop1: got %0d expected 60", $signed(pops[1]));
      end
    end
  endtask

  task automatic test_write_reject();
    logic [13:0] r, rr;
    int lat;
    win_valid = 1'b1;
    win_data  = tap12(640);
    @(negedge clk);
    wr_en = 1'b1; wr_ch = 2'd0; wr_idx = 5'd12; wr_data = 8'd5;
    @(negedge clk);
    wr_en = 1'b0;
    n_cmp++;
    if (wr_err !== 1'b1) begin
      n_bad++; $display("FAIL busy_write_err: got %b expected 1", wr_err);
    end
    @(negedge clk);
    win_valid = 1'b0;
    n_cmp++;
    if (wr_err !== 1'b0) begin
      n_bad++; $display("FAIL busy_write_pulse: got %b expected 0", wr_err);
    end
    lat = -1;
    r = 'x;
    for (int n = 1; n <= 10; n++) begin
      if (out_valid) begin
        lat = n; r = out_data; break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    n_cmp++;
    if (r !== 14'd30 || lat !== 2) begin
      n_bad++; $display("FAIL busy_write_pixel: got %0d lat %0d expected 30 lat 2",
                        $signed(r), lat);
    end
    run_pixel(tap12(640), tap12(640), tap12(640), r, rr, lat);
    n_cmp++;
    if (r !== 14'd30) begin
      n_bad++; $display("FAIL weight_kept: got %0d expected 30", $signed(r));
    end
    write_w(0, NT + 1, 7);
    n_cmp++;
    if (wr_err !== 1'b1) begin
      n_bad++; $display("FAIL bad_idx_err: got %b expected 1", wr_err);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [13:0] r, rr;
    int lat;
    win_valid = 1'b1;
    win_data  = tap12(640);
    @(negedge clk);
    win_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_state: got busy=%b valid=%b expected 0 0",
                        busy, out_valid);
    end
    run_pixel(tap12(640), tap12(640), tap12(640), r, rr, lat);
    n_cmp++;
    if (r !== 14'd0) begin
      n_bad++; $display("FAIL mid_reset_weights: got %0d expected 0", $signed(r));
    end
    set_tap12();
    run_pixel(tap12(640), tap12(1280), tap12(640), r, rr, lat);
    n_cmp++;
    if (r !== 14'd40 || lat !== 2) begin
      n_bad++; $display("FAIL mid_reset_reload: got %0d lat %0d expected 40 lat 2",
                        $signed(r), lat);
    end
  endtask

  initial begin
    test_reset();
    test_zero_weights();
    test_basic();
    test_saturation();
    test_backpressure();
    test_write_reject();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
